// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle for seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) ();
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             tx_en;
  logic             abort;
  logic             x_out;
  logic             x_valid;
  logic             sof;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, gap, tx_en, abort,
    input  x_out, x_valid, sof, busy, done
  );

  modport slave (
    input  start, repeat_cnt, gap, tx_en, abort,
    output x_out, x_valid, sof, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern burst transmitter paced by a bit-rate enable
module seq_pattern_tx #(
  parameter int               PAT_W   = 7,
  parameter logic [PAT_W-1:0] PATTERN = 7'b1110010,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  seq_pattern_tx_if.slave bus
);

  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] frames_left;
  logic [GAP_W-1:0] gap_ctr;
  logic [GAP_W-1:0] gap_lat;
  logic [IW-1:0]    bit_sel;
  logic             last_bit;

  // Out-of-range idx is folded onto the last bit so it always terminates the frame.
  assign last_bit = (idx >= LAST);
  assign bit_sel  = last_bit ? '0 : (LAST - idx);

  assign bus.x_valid = (state == SEND);
  assign bus.x_out   = (state == SEND) && PATTERN[bit_sel];
  assign bus.sof     = (state == SEND) && (idx == '0);
  assign bus.busy    = (state == SEND) || (state == GAP);
  assign bus.done    = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      frames_left <= '0;
      gap_ctr     <= '0;
      gap_lat     <= '0;
    end else if (bus.abort) begin
      state       <= IDLE;
      idx         <= '0;
      frames_left <= '0;
      gap_ctr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            gap_lat     <= bus.gap;
            idx         <= '0;
            frames_left <= bus.repeat_cnt;
            state       <= (bus.repeat_cnt != '0) ? SEND : DONE;
          end
        end
        SEND: begin
          if (bus.tx_en) begin
            if (last_bit) begin
              idx         <= '0;
              frames_left <= frames_left - 1'b1;
              if (frames_left <= CNT_W'(1)) begin
                state <= DONE;
              end else if (gap_lat != '0) begin
                gap_ctr <= gap_lat;
                state   <= GAP;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        GAP: begin
          if (bus.tx_en) begin
            if (gap_ctr <= GAP_W'(1)) begin
              gap_ctr <= '0;
              state   <= SEND;
            end else begin
              gap_ctr <= gap_ctr - 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It emits a fixed bit pattern (default 111_0010, MSB first) on a single-bit line as a burst of back-to-back or gap-separated frames. It is the generating end of the serial sequence-check path, driving the serial input of the team's sequence detector, either as a loopback stimulus source or as a link preamble/sync generator. A bit-rate enable paces the output, and a start/busy/done control interface drives the block.

Parameters:
PAT_W, 7, pattern length in bits (≥2)
PATTERN, 7'b1110010, pattern; bit PAT_W-1 is sent first
CNT_W, 8, width of the frame repeat count
GAP_W, 4, width of the inter-frame gap count (in bit-times)

Ports:
clk  in  1  clock
reset  in  1  async active-low reset
start  in  1  single-cycle request, sampled only in IDLE
repeat_cnt  in  CNT_W  number of frames to send, latched on accepted start
gap  in  GAP_W  idle bit-times between frames, latched on accepted start
tx_en  in  1  bit-rate enable; one bit-time elapses per cycle with tx_en=1
abort  in  1  synchronous cancel
x_out  out  1  serial data
x_valid  out  1  x_out carries a pattern bit
sof  out  1  high while the first bit of a frame is presented
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset is asynchronous and active-low, named reset; clock is clk.
- Reset state: state=IDLE, idx=0, frames_left=0, gap_ctr=0. Outputs: x_out=0, x_valid=0, sof=0, busy=0, done=0.
- Outputs are decoded only from registered state, idx and gap_ctr. There is no combinational path from any input to any output.
- States are IDLE, SEND, GAP and DONE. Use a binary encoding.
- IDLE:
  - start=1 and abort=0 → latch repeat_cnt and gap.
  - If repeat_cnt≠0: go to SEND with idx=0 and frames_left=repeat_cnt.
  - If repeat_cnt=0: go to DONE. No bits are sent.
- SEND:
  - x_valid=1, x_out=PATTERN[PAT_W-1-idx], busy=1, sof=(idx==0).
  - Bit is held while tx_en=0. On tx_en=1, the bit counts as sent and idx increments.
  - On tx_en=1 with idx==PAT_W-1 (last bit): idx←0 and frames_left decrements.
    - If frames_left was 1: go to DONE.
    - Else if latched gap=0: stay in SEND; the next frame follows with no idle bit.
    - Else: go to GAP with gap_ctr=gap.
- GAP:
  - x_valid=0, x_out=0, busy=1.
  - gap_ctr decrements on tx_en=1. On tx_en=1 with gap_ctr==1: go to SEND.
  - Result: exactly `gap` enabled cycles of idle.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- start in SEND or GAP is ignored; a new request needs IDLE.
- abort=1 in SEND, GAP or DONE → IDLE next cycle.
  - done is not pulsed. If abort hits DONE, the pulse already showing in that cycle stands.
  - x_valid and busy drop the next cycle, and the partial frame is truncated.
- abort and start together in IDLE: abort wins and start is dropped.
- Latency: start accepted on edge T → first bit valid in cycle T+1.
- With tx_en held high, N frames with gap G take N·PAT_W + (N-1)·G cycles. done is asserted in the cycle after the last bit.
- Counter widths: frames_left is CNT_W bits, gap_ctr is GAP_W bits, idx is clog2(PAT_W) bits. No wrap is reachable in legal operation. An idx value ≥PAT_W is treated as the last bit.
- Reset asserted mid-transfer: immediate return to reset values, no done.

Test Plan:
- Reset, tx_en=1, start with repeat_cnt=1 and gap=0 at cycle 0:
  - x_out=1,1,1,0,0,1,0 with x_valid=1 in cycles 1–7, sof only in cycle 1.
  - done in cycle 8. busy high in cycles 1–7.
  - Seq-detector loopback: y asserts after the 7th bit.
- repeat_cnt=2, gap=3, tx_en=1:
  - Bits in cycles 1–7, x_valid=0 in cycles 8–10, bits in cycles 11–17.
  - sof in cycles 1 and 11, done in cycle 18.
- repeat_cnt=3, gap=0: 21 contiguous valid bits, sof in cycles 1, 8 and 15, done in cycle 22.
- tx_en toggling 1,0,1,0…, repeat_cnt=1:
  - Each bit is held 2 cycles, so 14 valid cycles.
  - Pattern order is unchanged and no bit is skipped or duplicated.
- abort during the 4th bit of frame 1 of 2: x_valid=0 and busy=0 next cycle, done never pulses. A new start is accepted the cycle after.
- Edge cases:
  - repeat_cnt=0: done pulses in cycle 1 with x_valid never high.
  - start during busy: ignored.
  - start+abort in IDLE: no transfer.
  - reset low mid-frame: outputs are at reset values immediately.
